// File: rtl/multi_wave_gen.sv
// multi_wave_gen
//   Multi-mode periodic waveform generator driven by one phase accumulator.
//   Produces one registered sample per enabled clock in one of four shapes:
//   sawtooth, triangle, square (programmable duty) or rhomboid.
//   Mode and duty are held in shadow registers. These registers only reload
//   while idle, on a synchronous clear, or on a phase wrap. A period in
//   progress therefore never changes shape partway through.
//
// Ports
//   clk_i         rising-edge clock
//   rst_ni        asynchronous reset, active-low
//   en_i          advance phase and emit one sample
//   sync_clr_i    synchronous phase clear, takes priority over en_i
//   mode_i        requested mode: 0 SAW, 1 TRI, 2 SQUARE, 3 RHOMB
//   step_i        phase increment per enabled cycle
//   duty_i        SQUARE threshold, output high while phase < duty
//   wave_o        registered sample
//   wave_valid_o  wave_o holds a new sample this cycle
//   wrap_o        phase wrapped on the previous edge
module multi_wave_gen #(
  parameter int WIDTH = 8
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             en_i,
  input  logic             sync_clr_i,
  input  logic [1:0]       mode_i,
  input  logic [WIDTH-1:0] step_i,
  input  logic [WIDTH-1:0] duty_i,
  output logic [WIDTH-1:0] wave_o,
  output logic             wave_valid_o,
  output logic             wrap_o
);

  typedef enum logic [1:0] {
    MODE_SAW    = 2'd0,
    MODE_TRI    = 2'd1,
    MODE_SQUARE = 2'd2,
    MODE_RHOMB  = 2'd3
  } mode_e;

  localparam logic [WIDTH-1:0] HALF    = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [WIDTH-1:0] HALF_M1 = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] MAX     = {WIDTH{1'b1}};

  logic [WIDTH-1:0] phase_q, phase_d;
  logic [WIDTH-1:0] wave_q, wave_d;
  logic [WIDTH-1:0] duty_q, duty_d;
  mode_e            mode_q, mode_d;
  logic             valid_q, valid_d;
  logic             wrap_q, wrap_d;

  logic [WIDTH:0]   sum;
  logic [WIDTH-1:0] tri_t;
  logic [WIDTH-1:0] sample;
  logic             load;

  // The extra bit of the sum is the wrap carry.
  assign sum   = {1'b0, phase_q} + {1'b0, step_i};
  assign tri_t = {phase_q[WIDTH-2:0], 1'b0};

  always_comb begin
    sample = phase_q;
    case (mode_q)
      MODE_SAW:    sample = phase_q;
      MODE_TRI:    sample = phase_q[WIDTH-1] ? ~tri_t : tri_t;
      MODE_SQUARE: sample = (phase_q < duty_q) ? MAX : '0;
      MODE_RHOMB: begin
        // Odd and even phases are mirrored about the centre line.
        // This interleaves two opposite ramps.
        if (!phase_q[WIDTH-1])
          sample = phase_q[0] ? (HALF_M1 + phase_q) : (HALF_M1 - phase_q);
        else
          sample = phase_q[0] ? (MAX - (phase_q - HALF_M1)) : (phase_q - HALF_M1);
      end
      default:     sample = phase_q;
    endcase
  end

  always_comb begin
    phase_d = phase_q;
    wave_d  = wave_q;
    mode_d  = mode_q;
    duty_d  = duty_q;
    valid_d = 1'b0;
    wrap_d  = 1'b0;
    load    = 1'b0;
    if (sync_clr_i) begin
      phase_d = '0;
      load    = 1'b1;
    end else if (en_i) begin
      wave_d  = sample;
      phase_d = sum[WIDTH-1:0];
      valid_d = 1'b1;
      wrap_d  = sum[WIDTH];
      // A new period picks up the new settings on the same edge as the new phase.
      load    = sum[WIDTH];
    end else begin
      load    = 1'b1;
    end
    if (load) begin
      mode_d = mode_e'(mode_i);
      duty_d = duty_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      phase_q <= '0;
      wave_q  <= '0;
      mode_q  <= MODE_SAW;
      duty_q  <= HALF;
      valid_q <= 1'b0;
      wrap_q  <= 1'b0;
    end else begin
      phase_q <= phase_d;
      wave_q  <= wave_d;
      mode_q  <= mode_d;
      duty_q  <= duty_d;
      valid_q <= valid_d;
      wrap_q  <= wrap_d;
    end
  end

  assign wave_o       = wave_q;
  assign wave_valid_o = valid_q;
  assign wrap_o       = wrap_q;

endmodule

// File: tb/tb_multi_wave_gen.sv
// Testbench for multi_wave_gen. Uses directed sequences with literal
// expectations and randomized traffic, and checks every cycle against a
// behavioural model.
module tb_multi_wave_gen;

  localparam int W    = 8;
  localparam int P    = 1 << W;
  localparam int HALF = P / 2;
  localparam int MAXV = P - 1;

  logic         clk;
  logic         rst_n;
  logic         en;
  logic         sync_clr;
  logic [1:0]   mode;
  logic [W-1:0] step;
  logic [W-1:0] duty;
  logic [W-1:0] wave;
  logic         wave_valid;
  logic         wrap;

  multi_wave_gen #(.WIDTH(W)) dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .en_i         (en),
    .sync_clr_i   (sync_clr),
    .mode_i       (mode),
    .step_i       (step),
    .duty_i       (duty),
    .wave_o       (wave),
    .wave_valid_o (wave_valid),
    .wrap_o       (wrap)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference shape functions, written directly from the waveform definitions.
  function automatic int f_ref(input int md, input int dt, input int p);
    case (md)
      0: return p;
      1: return (p < HALF) ? 2 * p : (2 * P - 1) - 2 * p;
      2: return (p < dt) ? MAXV : 0;
      default: begin
        if (p < HALF) return (p % 2) ? (HALF - 1) + p : (HALF - 1) - p;
        else          return (p % 2) ? MAXV - (p - (HALF - 1)) : p - (HALF - 1);
      end
    endcase
  endfunction

  // Behavioural model state
  int m_phase = 0, m_mode = 0, m_duty = HALF, m_wave = 0;
  int m_valid = 0, m_wrap = 0;

  always @(posedge clk or negedge rst_n) begin
    int s;
    if (!rst_n) begin
      m_phase = 0; m_mode = 0; m_duty = HALF; m_wave = 0; m_valid = 0; m_wrap = 0;
    end else if (sync_clr) begin
      m_phase = 0; m_valid = 0; m_wrap = 0;
      m_mode = int'(mode); m_duty = int'(duty);
    end else if (en) begin
      m_wave  = f_ref(m_mode, m_duty, m_phase);
      s       = m_phase + int'(step);
      m_valid = 1;
      m_wrap  = (s >= P) ? 1 : 0;
      m_phase = s % P;
      if (m_wrap == 1) begin
        m_mode = int'(mode); m_duty = int'(duty);
      end
    end else begin
      m_valid = 0; m_wrap = 0;
      m_mode = int'(mode); m_duty = int'(duty);
    end
  end

  typedef struct {
    int w;
    int wr;
  } smp_t;
  smp_t log_q[$];

  // Compare process: checks all outputs on every falling edge.
  always @(negedge clk) begin
    smp_t e;
    chk("wave", int'(wave), m_wave);
    chk("wave_valid", int'(wave_valid), m_valid);
    chk("wrap", int'(wrap), m_wrap);
    if (wave_valid) begin
      e.w  = int'(wave);
      e.wr = int'(wrap);
      log_q.push_back(e);
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  task automatic clear_to(input int md, input int st, input int dt);
    mode = 2'(md); step = W'(st); duty = W'(dt);
    en = 1'b0; sync_clr = 1'b1;
    tick(1);
    sync_clr = 1'b0;
  endtask

  int cnt;

  initial begin
    rst_n = 1'b0; en = 1'b0; sync_clr = 1'b0; mode = 2'd0; step = '0; duty = W'(HALF);

    // Pin the reference model against hand-computed values.
    chk("ref_rhomb_p3", f_ref(3, 0, 3), 130);
    chk("ref_rhomb_p128", f_ref(3, 0, 128), 1);
    chk("ref_tri_p128", f_ref(1, 0, 128), 255);
    chk("ref_sq_dmax_pmax", f_ref(2, 255, 255), 0);

    tick(3);
    chk("rst_wave", int'(wave), 0);
    chk("rst_valid", int'(wave_valid), 0);
    chk("rst_wrap", int'(wrap), 0);
    rst_n = 1'b1;

    // 1: sawtooth, 257 samples
    mode = 2'd0; step = W'(1); en = 1'b1;
    log_q.delete();
    tick(257);
    en = 1'b0;
    chk("t1_len", log_q.size(), 257);
    cnt = 0;
    for (int i = 0; i < log_q.size(); i++) begin
      if (log_q[i].w != i % P) cnt++;
    end
    chk("t1_saw_errs", cnt, 0);
    cnt = 0;
    for (int i = 0; i < log_q.size(); i++) cnt += log_q[i].wr;
    chk("t1_wrap_count", cnt, 1);
    chk("t1_wrap_pos", log_q[255].wr, 1);
    chk("t1_last", log_q[256].w, 0);

    // 2: triangle
    clear_to(1, 1, HALF);
    en = 1'b1; log_q.delete();
    tick(256);
    en = 1'b0;
    chk("t2_p0", log_q[0].w, 0);
    chk("t2_p127", log_q[127].w, 254);
    chk("t2_p128", log_q[128].w, 255);
    chk("t2_p255", log_q[255].w, 1);

    // 3: rhomboid
    clear_to(3, 1, HALF);
    en = 1'b1; log_q.delete();
    tick(256);
    en = 1'b0;
    chk("t3_p0", log_q[0].w, 127);
    chk("t3_p1", log_q[1].w, 128);
    chk("t3_p2", log_q[2].w, 125);
    chk("t3_p3", log_q[3].w, 130);
    chk("t3_p128", log_q[128].w, 1);
    chk("t3_p255", log_q[255].w, 127);

    // 4: square, duty change mid-period deferred to wrap
    clear_to(2, 4, 64);
    en = 1'b1; log_q.delete();
    tick(20);
    duty = W'(192);
    tick(108);
    en = 1'b0;
    chk("t4_len", log_q.size(), 128);
    cnt = 0;
    for (int i = 0; i < 64; i++) if (log_q[i].w == MAXV) cnt++;
    chk("t4_high_p1", cnt, 16);
    chk("t4_p1_s15", log_q[15].w, 255);
    chk("t4_p1_s16", log_q[16].w, 0);
    cnt = 0;
    for (int i = 64; i < 128; i++) if (log_q[i].w == MAXV) cnt++;
    chk("t4_high_p2", cnt, 48);

    // 5: SAW -> TRI switch at phase 100 applies only after the wrap
    clear_to(0, 1, HALF);
    en = 1'b1; log_q.delete();
    tick(100);
    mode = 2'd1;
    tick(160);
    en = 1'b0;
    chk("t5_p200", log_q[200].w, 200);
    chk("t5_p255", log_q[255].w, 255);
    chk("t5_tri0", log_q[256].w, 0);
    chk("t5_tri1", log_q[257].w, 2);

    // 6: sync_clr at phase 77, en gaps, reset mid-period
    clear_to(0, 1, HALF);
    en = 1'b1;
    tick(77);
    sync_clr = 1'b1;
    tick(1);
    chk("t6_clr_valid", int'(wave_valid), 0);
    chk("t6_clr_hold", int'(wave), 76);
    sync_clr = 1'b0;
    tick(1);
    chk("t6_after_clr", int'(wave), 0);
    en = 1'b0;
    tick(3);
    chk("t6_gap_wave", int'(wave), 0);
    chk("t6_gap_valid", int'(wave_valid), 0);
    en = 1'b1;
    tick(10);
    mode = 2'd3;
    rst_n = 1'b0;
    #1;
    chk("t6_async_wave", int'(wave), 0);
    chk("t6_async_valid", int'(wave_valid), 0);
    tick(2);
    rst_n = 1'b1; mode = 2'd1;
    log_q.delete();
    tick(3);
    en = 1'b0;
    chk("t6_post_rst_s1", log_q[1].w, 1);
    chk("t6_post_rst_s2", log_q[2].w, 2);

    // Randomized traffic, checked against the model every cycle.
    for (int i = 0; i < 3000; i++) begin
      rst_n    = ($urandom_range(0, 199) == 0) ? 1'b0 : 1'b1;
      en       = ($urandom_range(0, 3) != 0) ? 1'b1 : 1'b0;
      sync_clr = ($urandom_range(0, 31) == 0) ? 1'b1 : 1'b0;
      if ($urandom_range(0, 7) == 0) mode = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 7) == 0) duty = W'($urandom_range(0, MAXV));
      if ($urandom_range(0, 15) == 0)
        step = ($urandom_range(0, 5) == 0) ? '0 : W'($urandom_range(1, 40));
      tick(1);
    end
    rst_n = 1'b1; en = 1'b0; sync_clr = 1'b0;
    tick(2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
